// File: rtl/register_bank.sv
// DEPTH x N register bank with per-entry valid bits, a live-entry counter and a registered read port.
// Optional `BANK_BYPASS_EN forwards same-cycle write data to a same-address read.
module register_bank #(
    parameter int N     = 32,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [N-1:0]  wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    input  logic          clear,
    output logic [N-1:0]  rd_data,
    output logic          rd_valid,
    output logic          rd_hit,
    output logic [AW:0]   count
);

    logic [N-1:0]     mem_q [DEPTH];
    logic [N-1:0]     mem_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [AW:0]      count_q, count_d;
    logic [N-1:0]     rd_data_q, rd_data_d;
    logic             rd_valid_q, rd_valid_d;
    logic             rd_hit_q, rd_hit_d;

    // Storage is not reset; only the valid bits define what the bank holds.
    always_comb begin
        mem_d = mem_q;
        if (wr_en) begin
            mem_d[wr_addr] = wr_data;
        end
    end

    // A clear in the same cycle as a write wipes everything else, so the write lands in an empty bank.
    always_comb begin
        valid_d = clear ? '0 : valid_q;
        count_d = clear ? '0 : count_q;
        if (wr_en) begin
            valid_d[wr_addr] = 1'b1;
            if (clear || !valid_q[wr_addr]) begin
                count_d = count_d + 1'b1;
            end
        end
    end

    // Read handshake: rd_en at edge T yields exactly one rd_valid pulse at T+1 with rd_data/rd_hit
    // taken from the state before edge T; there is no backpressure, and idle cycles hold data/hit.
    always_comb begin
        rd_valid_d = rd_en;
        rd_data_d  = rd_data_q;
        rd_hit_d   = rd_hit_q;
        if (rd_en) begin
            rd_hit_d  = valid_q[rd_addr];
            rd_data_d = valid_q[rd_addr] ? mem_q[rd_addr] : '0;
`ifdef BANK_BYPASS_EN
            if (wr_en && (wr_addr == rd_addr)) begin
                rd_hit_d  = 1'b1;
                rd_data_d = wr_data;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            valid_q    <= '0;
            count_q    <= '0;
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
            rd_hit_q   <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            count_q    <= count_d;
            rd_data_q  <= rd_data_d;
            rd_valid_q <= rd_valid_d;
            rd_hit_q   <= rd_hit_d;
        end
    end

    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
    assign rd_hit   = rd_hit_q;
    assign count    = count_q;

endmodule

// File: tb/tb_register_bank.sv
// Directed bench for register_bank (N=32, DEPTH=8); expectations follow `BANK_BYPASS_EN when defined.
module tb_register_bank;

    localparam int N     = 32;
    localparam int DEPTH = 8;
    localparam int AW    = $clog2(DEPTH);

    logic          clk;
    logic          reset;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [N-1:0]  wr_data;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          clear;
    logic [N-1:0]  rd_data;
    logic          rd_valid;
    logic          rd_hit;
    logic [AW:0]   count;

    int checks   = 0;
    int failures = 0;
    logic [N-1:0] exp_q[$];

    register_bank #(.N(N), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rd_en    (rd_en),
        .rd_addr  (rd_addr),
        .clear    (clear),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_hit   (rd_hit),
        .count    (count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Driver tasks
    task automatic do_write(input logic [AW-1:0] a, input logic [N-1:0] d);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic do_read(input logic [AW-1:0] a);
        rd_en = 1'b1; rd_addr = a;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic check_read(input string tag, input logic [N-1:0] d, input logic h);
        check({tag, "_valid"}, 64'(rd_valid), 64'd1);
        check({tag, "_hit"}, 64'(rd_hit), 64'(h));
        check({tag, "_data"}, 64'(rd_data), 64'(d));
    endtask

    initial begin
        logic [N-1:0] exp_v;
        reset = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0; clear = 1'b0;
        tick();
        tick();
        check("rst_valid", 64'(rd_valid), 64'd0);
        check("rst_hit", 64'(rd_hit), 64'd0);
        check("rst_data", 64'(rd_data), 64'd0);
        check("rst_count", 64'(count), 64'd0);
        reset = 1'b1;
        tick();

        do_read(3'd3);
        check_read("empty_rd3", 32'h0, 1'b0);
        check("empty_count", 64'(count), 64'd0);

        do_write(3'd2, 32'hDEAD_BEEF);
        check("wr2_count", 64'(count), 64'd1);
        do_read(3'd2);
        check_read("rd2", 32'hDEAD_BEEF, 1'b1);
        tick();
        check("idle_valid", 64'(rd_valid), 64'd0);
        check("idle_hold_data", 64'(rd_data), 64'hDEAD_BEEF);
        check("idle_hold_hit", 64'(rd_hit), 64'd1);
        do_write(3'd2, 32'h1);
        check("rewrite_count", 64'(count), 64'd1);

        for (int i = 0; i < DEPTH; i++) begin
            do_write(AW'(i), N'(i * 3));
        end
        check("fill_count", 64'(count), 64'd8);

        // Back-to-back readback through the expected queue
        for (int i = 0; i < DEPTH; i++) begin
            rd_en = 1'b1; rd_addr = AW'(i);
            exp_q.push_back(N'(i * 3));
            tick();
            exp_v = exp_q.pop_front();
            check("b2b_valid", 64'(rd_valid), 64'd1);
            check("b2b_data", 64'(rd_data), 64'(exp_v));
        end
        rd_en = 1'b0;
        tick();
        check("b2b_end_valid", 64'(rd_valid), 64'd0);

        do_write(3'd5, 32'hA);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 32'hB;
        rd_en = 1'b1; rd_addr = 3'd5;
        tick();
        wr_en = 1'b0; rd_en = 1'b0;
`ifdef BANK_BYPASS_EN
        check_read("same_addr", 32'hB, 1'b1);
`else
        check_read("same_addr", 32'hA, 1'b1);
`endif
        do_read(3'd5);
        check_read("after_same", 32'hB, 1'b1);
        check("pre_clear_count", 64'(count), 64'd8);

        clear = 1'b1; wr_en = 1'b1; wr_addr = 3'd1; wr_data = 32'h55;
        tick();
        clear = 1'b0; wr_en = 1'b0;
        check("clr_wr_count", 64'(count), 64'd1);
        do_read(3'd1);
        check_read("clr_rd1", 32'h55, 1'b1);
        do_read(3'd4);
        check_read("clr_rd4", 32'h0, 1'b0);

        // Reset one edge after a read: the pulse appears, then reset clears it
        rd_en = 1'b1; rd_addr = 3'd1;
        tick();
        rd_en = 1'b0;
        check("pre_rst_valid", 64'(rd_valid), 64'd1);
        reset = 1'b0;
        tick();
        check("rst_rd_valid", 64'(rd_valid), 64'd0);
        check("rst_rd_count", 64'(count), 64'd0);
        check("rst_rd_data", 64'(rd_data), 64'd0);
        reset = 1'b1;
        rd_en = 1'b1; rd_addr = 3'd1;
        reset = 1'b0;
        tick();
        rd_en = 1'b0;
        reset = 1'b1;
        check("rst_same_edge_valid", 64'(rd_valid), 64'd0);
        do_write(3'd6, 32'h77);
        check("post_rst_count", 64'(count), 64'd1);
        do_read(3'd6);
        check_read("post_rst_rd6", 32'h77, 1'b1);

        clear = 1'b1; rd_en = 1'b1; rd_addr = 3'd6;
        tick();
        clear = 1'b0; rd_en = 1'b0;
        check_read("clr_rd_old", 32'h77, 1'b1);
        check("clr_rd_count", 64'(count), 64'd0);
        do_read(3'd6);
        check_read("after_clr_rd6", 32'h0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
